mdu_seq_ctrl: RTL and testbench
===============================

# mdu_seq_ctrl

Multi-cycle sequencing controller for the M-extension datapath. It sits between decode and execute, next to the combinational instruction controller. It accepts MDU operations flagged by decode, starts the multi-cycle multiply/divide unit, and counts its parametrised latency. It stalls the front end until the result is written back, and handles flush and divide-by-zero.

## Interface
Parameters:
- MUL_CYCLES, 3, MDU cycles for MUL/MULH/MULHSU/MULHU; must be ≥1.
- DIV_CYCLES, 34, MDU cycles for DIV/DIVU/REM/REMU; must be ≥1.
- OP_WIDTH, 3, MDU op code width.
- RD_WIDTH, 5, destination register address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- id_valid_i  in  1  decode stage holds a valid instruction.
- md_op_i  in  1  the instruction is an MDU operation.
- mdu_op_i  in  OP_WIDTH  MDU op code: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- rd_addr_i  in  RD_WIDTH  destination register.
- rs2_zero_i  in  1  rs2 operand equals zero.
- flush_i  in  1  pipeline flush.
- ex_ready_i  in  1  writeback accepts the result.
- stall_o  out  1  hold decode/fetch.
- mdu_start_o  out  1  one-cycle start pulse to the MDU.
- mdu_op_o  out  OP_WIDTH  latched op code.
- mdu_kill_o  out  1  abort the in-flight MDU operation.
- result_valid_o  out  1  MDU result ready for writeback.
- wb_rd_addr_o  out  RD_WIDTH  latched destination register.
- div_zero_o  out  1  result must take the RISC-V divide-by-zero value.
- busy_o  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE, RUN, DONE.
- Counter:
  - Width is $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
- Divide ops:
  - An op is a divide when mdu_op bit 2 is set.
- accept = IDLE & id_valid_i & md_op_i & ~flush_i.
- IDLE:
  - On accept, latch mdu_op_i and rd_addr_i, load cnt = N−1 (N = DIV_CYCLES for divide ops, else MUL_CYCLES), and go to RUN.
- RUN:
  - mdu_start_o = 1 in the first RUN cycle only.
  - cnt decrements each cycle.
  - When cnt == 0, go to DONE.
- DONE:
  - result_valid_o = 1.
  - With ex_ready_i = 1, go to IDLE; otherwise hold DONE with all latched outputs stable.
- stall_o (combinational) = accept | RUN | (DONE & ~ex_ready_i).
  - Upstream advances in the DONE/ex_ready cycle.
  - The still-present instruction is never re-accepted because state ≠ IDLE that cycle.
- Flush:
  - flush_i in RUN or DONE: next state IDLE, mdu_kill_o = 1 that cycle, result_valid_o forced 0 that cycle.
  - flush_i in IDLE blocks accept; mdu_kill_o stays 0.
  - Flush has priority over ex_ready_i and over accept.
- Non-MDU instructions (md_op_i = 0) never affect the FSM.

## Timing
- Reset values:
  - state IDLE, cnt 0, mdu_op_o 0, wb_rd_addr_o 0, div_zero_o 0.
  - mdu_start_o, result_valid_o, busy_o and mdu_kill_o are 0.
  - stall_o follows the accept term and is 0 while rst_n = 0.
- Latency for an accept in cycle T:
  - mdu_start_o is high in T+1.
  - result_valid_o is first high in T+N+1.
  - The earliest next accept is T+N+2 (with ex_ready_i = 1 at T+N+1).
- Back-to-back MDU ops: each costs N+1 cycles of stall plus any writeback backpressure cycles.
- Reset asserted mid-operation: immediate return to IDLE; no kill pulse is generated.

## Configuration
- MDU_DIV_ZERO_FAST_EN defined:
  - A divide op accepted with rs2_zero_i = 1 goes IDLE→DONE directly, with no RUN and no mdu_start_o.
  - div_zero_o = 1 in that DONE, so writeback selects all-ones (DIV/DIVU) or rs1 (REM/REMU).
  - Latency is 1 cycle (result_valid_o at T+1).
- Undefined:
  - rs2_zero_i is ignored and all divides take DIV_CYCLES.
  - div_zero_o is constant 0.

## Test plan
- MUL (op 0, rd 7) accepted at T with ex_ready_i = 1, MUL_CYCLES = 3:
  - Required: mdu_start_o at T+1, result_valid_o and wb_rd_addr_o = 7 at T+4, stall_o high T..T+3 and low at T+4.
- DIVU (op 5) with DIV_CYCLES = 34, ex_ready_i held 0 for 5 cycles after DONE:
  - Required: result_valid_o from T+35 held 6 cycles, stall_o high throughout, IDLE after the handshake.
- flush_i at T+2 of a DIV:
  - Required: mdu_kill_o = 1 at T+2, IDLE at T+3, no result_valid_o; a new MUL is accepted at T+3.
- DIV with rs2_zero_i = 1:
  - With MDU_DIV_ZERO_FAST_EN: result_valid_o and div_zero_o at T+1, no mdu_start_o.
  - Without it: result_valid_o at T+35, div_zero_o = 0.
- rst_n pulled low during RUN:
  - Required: all outputs 0 asynchronously, busy_o = 0 after release, next accept behaves as from reset.
- ADD (md_op_i = 0) with id_valid_i = 1:
  - Required: stall_o = 0 and busy_o = 0 throughout.

Source files
------------

// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl: MDU multi-cycle sequencer; MDU_DIV_ZERO_FAST_EN enables the divide-by-zero bypass
module mdu_seq_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 34,
  parameter int OP_WIDTH = 3,
  parameter int RD_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid_i,
  input  logic                md_op_i,
  input  logic [OP_WIDTH-1:0] mdu_op_i,
  input  logic [RD_WIDTH-1:0] rd_addr_i,
  input  logic                rs2_zero_i,
  input  logic                flush_i,
  input  logic                ex_ready_i,
  output logic                stall_o,
  output logic                mdu_start_o,
  output logic [OP_WIDTH-1:0] mdu_op_o,
  output logic                mdu_kill_o,
  output logic                result_valid_o,
  output logic [RD_WIDTH-1:0] wb_rd_addr_o,
  output logic                div_zero_o,
  output logic                busy_o
);
  localparam int MAXC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic accept, is_div, fast, active;
  assign is_div = mdu_op_i[2];
`ifdef MDU_DIV_ZERO_FAST_EN
  assign fast = is_div & rs2_zero_i;
`else
  logic unused_rs2_zero;
  assign unused_rs2_zero = rs2_zero_i;
  assign fast = 1'b0;
`endif
  // rst_n gates accept so stall stays low throughout reset
  assign accept = rst_n & (state == IDLE) & id_valid_i & md_op_i & ~flush_i;
  assign active = state != IDLE;
  assign stall_o = accept | (state == RUN) | ((state == DONE) & ~ex_ready_i);
  assign mdu_kill_o = active & flush_i;
  assign result_valid_o = (state == DONE) & ~flush_i;
  assign busy_o = active;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mdu_op_o <= '0;
      wb_rd_addr_o <= '0;
      div_zero_o <= 1'b0;
      mdu_start_o <= 1'b0;
    end else begin
      mdu_start_o <= accept & ~fast;
      if (mdu_kill_o) begin
        state <= IDLE;
        div_zero_o <= 1'b0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            mdu_op_o <= mdu_op_i;
            wb_rd_addr_o <= rd_addr_i;
            cnt <= fast ? '0 : is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
            div_zero_o <= fast;
            state <= fast ? DONE : RUN;
          end
          RUN: if (cnt == '0) state <= DONE;
               else cnt <= cnt - 1'b1;
          DONE: if (ex_ready_i) begin
            state <= IDLE;
            div_zero_o <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// tb_mdu_seq_ctrl: directed checks of mdu_seq_ctrl with default latencies (MUL 3, DIV 34)
module tb_mdu_seq_ctrl;
  logic clk = 0, rst_n = 0;
  logic id_valid_i = 0, md_op_i = 0, rs2_zero_i = 0, flush_i = 0, ex_ready_i = 0;
  logic [2:0] mdu_op_i = 0;
  logic [4:0] rd_addr_i = 0;
  logic stall_o, mdu_start_o, mdu_kill_o, result_valid_o, div_zero_o, busy_o;
  logic [2:0] mdu_op_o;
  logic [4:0] wb_rd_addr_o;
  int errors = 0, checks = 0;
  mdu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .md_op_i(md_op_i),
    .mdu_op_i(mdu_op_i), .rd_addr_i(rd_addr_i), .rs2_zero_i(rs2_zero_i),
    .flush_i(flush_i), .ex_ready_i(ex_ready_i), .stall_o(stall_o),
    .mdu_start_o(mdu_start_o), .mdu_op_o(mdu_op_o), .mdu_kill_o(mdu_kill_o),
    .result_valid_o(result_valid_o), .wb_rd_addr_o(wb_rd_addr_o),
    .div_zero_o(div_zero_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] op, input logic [4:0] rd);
    id_valid_i = 1; md_op_i = 1; mdu_op_i = op; rd_addr_i = rd;
  endtask
  task automatic idle_in;
    id_valid_i = 0; md_op_i = 0;
  endtask
  initial begin
    issue(0, 9);
    cyc; #1;
    chk("rst_stall", stall_o, 0); chk("rst_busy", busy_o, 0); chk("rst_start", mdu_start_o, 0);
    chk("rst_valid", result_valid_o, 0); chk("rst_kill", mdu_kill_o, 0); chk("rst_op", mdu_op_o, 0);
    chk("rst_rd", wb_rd_addr_o, 0); chk("rst_dz", div_zero_o, 0);
    idle_in; rst_n = 1;
    cyc;
    // MUL, decode holds the instruction until stall drops
    ex_ready_i = 1; issue(0, 7); #1;
    chk("mul_t_stall", stall_o, 1); chk("mul_t_start", mdu_start_o, 0);
    cyc; #1;
    chk("mul_t1_start", mdu_start_o, 1); chk("mul_t1_stall", stall_o, 1); chk("mul_t1_busy", busy_o, 1);
    cyc; #1;
    chk("mul_t2_start", mdu_start_o, 0); chk("mul_t2_stall", stall_o, 1);
    cyc; #1;
    chk("mul_t3_stall", stall_o, 1); chk("mul_t3_valid", result_valid_o, 0);
    cyc; #1;
    chk("mul_t4_valid", result_valid_o, 1); chk("mul_t4_rd", wb_rd_addr_o, 7); chk("mul_t4_stall", stall_o, 0);
    cyc; idle_in; #1;
    chk("mul_t5_busy", busy_o, 0); chk("mul_t5_valid", result_valid_o, 0); chk("mul_t5_start", mdu_start_o, 0);
    // DIVU with writeback backpressure
    cyc; ex_ready_i = 0; issue(5, 3); #1;
    chk("divu_t_stall", stall_o, 1);
    cyc; idle_in; #1;
    chk("divu_t1_start", mdu_start_o, 1); chk("divu_t1_op", mdu_op_o, 5);
    for (int i = 2; i <= 34; i++) begin
      cyc; #1;
      chk("divu_run_valid", result_valid_o, 0); chk("divu_run_stall", stall_o, 1);
    end
    for (int i = 35; i <= 39; i++) begin
      cyc; #1;
      chk("divu_bp_valid", result_valid_o, 1); chk("divu_bp_stall", stall_o, 1); chk("divu_bp_rd", wb_rd_addr_o, 3);
    end
    cyc; ex_ready_i = 1; #1;
    chk("divu_hs_valid", result_valid_o, 1); chk("divu_hs_stall", stall_o, 0);
    cyc; #1;
    chk("divu_after_busy", busy_o, 0); chk("divu_after_valid", result_valid_o, 0);
    // flush during RUN, then immediate new MUL
    cyc; issue(4, 2); #1;
    chk("fl_t_stall", stall_o, 1);
    cyc; idle_in; #1;
    chk("fl_t1_start", mdu_start_o, 1);
    cyc; flush_i = 1; #1;
    chk("fl_t2_kill", mdu_kill_o, 1); chk("fl_t2_valid", result_valid_o, 0);
    cyc; flush_i = 0; issue(0, 11); #1;
    chk("fl_t3_busy", busy_o, 0); chk("fl_t3_kill", mdu_kill_o, 0); chk("fl_t3_stall", stall_o, 1);
    cyc; idle_in; #1;
    chk("fl_mul_start", mdu_start_o, 1); chk("fl_mul_op", mdu_op_o, 0); chk("fl_mul_rd", wb_rd_addr_o, 11);
    cyc; cyc; cyc; #1;
    chk("fl_mul_valid", result_valid_o, 1);
    cyc;
    // flush while DONE waits on writeback
    ex_ready_i = 0; issue(1, 4); #1;
    cyc; idle_in; cyc; cyc; cyc; #1;
    chk("fd_valid", result_valid_o, 1); chk("fd_op", mdu_op_o, 1);
    cyc; flush_i = 1; #1;
    chk("fd_flush_valid", result_valid_o, 0); chk("fd_flush_kill", mdu_kill_o, 1);
    cyc; flush_i = 0; #1;
    chk("fd_after_busy", busy_o, 0); chk("fd_after_kill", mdu_kill_o, 0);
    // flush in IDLE blocks accept without a kill
    issue(0, 5); flush_i = 1; #1;
    chk("fi_stall", stall_o, 0); chk("fi_kill", mdu_kill_o, 0);
    cyc; #1;
    chk("fi_busy", busy_o, 0);
    flush_i = 0; idle_in;
    // divide by zero
    ex_ready_i = 1; rs2_zero_i = 1; issue(4, 6); #1;
    chk("dz_t_stall", stall_o, 1);
    cyc; idle_in; rs2_zero_i = 0; #1;
`ifdef MDU_DIV_ZERO_FAST_EN
    chk("dz_fast_valid", result_valid_o, 1); chk("dz_fast_flag", div_zero_o, 1); chk("dz_fast_start", mdu_start_o, 0);
`else
    chk("dz_start", mdu_start_o, 1);
    repeat (33) cyc;
    #1;
    chk("dz_t34_valid", result_valid_o, 0);
    cyc; #1;
    chk("dz_t35_valid", result_valid_o, 1); chk("dz_t35_flag", div_zero_o, 0);
`endif
    cyc; #1;
    chk("dz_after_busy", busy_o, 0); chk("dz_after_flag", div_zero_o, 0);
    // asynchronous reset during RUN
    issue(0, 1); #1;
    cyc; idle_in; #1;
    chk("rr_start", mdu_start_o, 1);
    cyc; #1;
    chk("rr_busy_run", busy_o, 1);
    rst_n = 0; issue(2, 8); #1;
    chk("rr_busy", busy_o, 0); chk("rr_start0", mdu_start_o, 0); chk("rr_valid", result_valid_o, 0);
    chk("rr_kill", mdu_kill_o, 0); chk("rr_stall", stall_o, 0); chk("rr_rd", wb_rd_addr_o, 0);
    cyc; rst_n = 1; #1;
    chk("rr_rel_busy", busy_o, 0); chk("rr_rel_stall", stall_o, 1);
    cyc; idle_in; #1;
    chk("rr_new_start", mdu_start_o, 1); chk("rr_new_op", mdu_op_o, 2); chk("rr_new_rd", wb_rd_addr_o, 8);
    cyc; cyc; cyc; #1;
    chk("rr_new_valid", result_valid_o, 1);
    cyc; #1;
    chk("rr_new_idle", busy_o, 0);
    // non-MDU instruction
    id_valid_i = 1; md_op_i = 0; mdu_op_i = 4;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("add_stall", stall_o, 0); chk("add_busy", busy_o, 0);
      cyc;
    end
    idle_in;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
